// File: rtl/logical_arbiter.sv
// Two-requester round-robin front end for a shared 32-bit logical unit.
// One operation is in flight at a time: IDLE (grant/capture) -> EXEC -> RESP.
module logical_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_op1,
  input  logic [31:0] req0_op2,
  input  logic [31:0] req1_op1,
  input  logic [31:0] req1_op2,
  input  logic [2:0]  req0_operation,
  input  logic [2:0]  req1_operation,
  output logic [31:0] lu_op1,
  output logic [31:0] lu_op2,
  output logic [2:0]  lu_operation,
  input  logic [31:0] lu_res,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [31:0] resp_res,
  output logic        resp_err,
  input  logic        resp_ready
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [2:0]  opc_q, opc_d;
  logic        id_q, id_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_id_q, resp_id_d;
  logic [31:0] resp_res_q, resp_res_d;
  logic        resp_err_q, resp_err_d;

  logic        grant_id;
  logic        opc_legal;

  // Contention goes to prio; a lone requester wins regardless of prio.
  always_comb begin
    if (req0_valid && req1_valid) grant_id = prio_q;
    else                          grant_id = req1_valid;
  end

  always_comb begin
    case (opc_q)
      3'b001, 3'b010, 3'b011, 3'b100: opc_legal = 1'b1;
      default:                        opc_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    opc_d        = opc_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_res_d   = resp_res_q;
    resp_err_d   = resp_err_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        if ((req0_valid || req1_valid) && !rst) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          op1_d      = grant_id ? req1_op1 : req0_op1;
          op2_d      = grant_id ? req1_op2 : req0_op2;
          opc_d      = grant_id ? req1_operation : req0_operation;
          id_d       = grant_id;
          prio_d     = ~grant_id;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        resp_id_d    = id_q;
        resp_valid_d = 1'b1;
        resp_res_d   = opc_legal ? lu_res : '0;
        resp_err_d   = ~opc_legal;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      op1_q        <= '0;
      op2_q        <= '0;
      opc_q        <= '0;
      id_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_res_q   <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      opc_q        <= opc_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_res_q   <= resp_res_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign lu_op1       = op1_q;
  assign lu_op2       = op2_q;
  assign lu_operation = opc_q;
  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_res     = resp_res_q;
  assign resp_err     = resp_err_q;

endmodule

// File: tb/tb_logical_arbiter.sv
// Directed bench for logical_arbiter; the shared logical unit is modelled here.
module tb_logical_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [2:0]  req0_operation, req1_operation;
  logic [31:0] lu_op1, lu_op2;
  logic [2:0]  lu_operation;
  logic [31:0] lu_res;
  logic        resp_valid, resp_id, resp_err, resp_ready;
  logic [31:0] resp_res;

  int checks = 0;
  int errors = 0;

  logic [2:0]  op_tab  [3] = '{3'b010, 3'b011, 3'b100};
  logic [31:0] exp_tab [3] = '{32'hA5A5_0000, 32'h0000_5A5A, 32'h5A5A_A5A5};

  always #5 clk = ~clk;

  // Reference logical unit; illegal opcodes return a poison value.
  always_comb begin
    case (lu_operation)
      3'b001:  lu_res = lu_op1 | lu_op2;
      3'b010:  lu_res = lu_op1 & lu_op2;
      3'b011:  lu_res = ~(lu_op1 | lu_op2);
      3'b100:  lu_res = lu_op1 ^ lu_op2;
      default: lu_res = 32'hDEAD_BEEF;
    endcase
  end

  logical_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req1_op1(req1_op1), .req1_op2(req1_op2),
    .req0_operation(req0_operation), .req1_operation(req1_operation),
    .lu_op1(lu_op1), .lu_op2(lu_op2), .lu_operation(lu_operation),
    .lu_res(lu_res),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_res(resp_res),
    .resp_err(resp_err), .resp_ready(resp_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_resp(input string tag, input logic id, input logic [31:0] res, input logic err);
    check({tag, "_valid"}, {31'b0, resp_valid}, 32'd1);
    check({tag, "_id"},    {31'b0, resp_id},    {31'b0, id});
    check({tag, "_res"},   resp_res,            res);
    check({tag, "_err"},   {31'b0, resp_err},   {31'b0, err});
  endtask

  task automatic chk_ready(input string tag, input logic r0, input logic r1);
    check({tag, "_r0"}, {31'b0, req0_ready}, {31'b0, r0});
    check({tag, "_r1"}, {31'b0, req1_ready}, {31'b0, r1});
  endtask

  initial begin
    // Reset with both requesters pending: no grant during reset.
    rst = 1'b1; resp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_op1 = '0; req0_op2 = '0; req1_op1 = '0; req1_op2 = '0;
    req0_operation = '0; req1_operation = '0;
    #1;
    chk_ready("rst_cycle", 1'b0, 1'b0);
    tick();
    chk_ready("rst_cycle2", 1'b0, 1'b0);
    check("rst_lu_op1", lu_op1, 32'h0);
    check("rst_lu_op2", lu_op2, 32'h0);
    check("rst_lu_opc", {29'b0, lu_operation}, 32'h0);
    check("rst_rvalid", {31'b0, resp_valid}, 32'h0);
    check("rst_rres", resp_res, 32'h0);
    check("rst_rerr", {31'b0, resp_err}, 32'h0);
    req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b0;
    tick();

    // Single request, OR; inputs scrambled during EXEC must not leak through.
    req0_op1 = 32'hF0F0_F0F0; req0_op2 = 32'h0F0F_FFFF; req0_operation = 3'b001;
    req0_valid = 1'b1;
    #1;
    chk_ready("single_accept", 1'b1, 1'b0);
    tick();
    req0_valid = 1'b1; req0_op1 = 32'h1234_5678; req0_operation = 3'b100;
    #1;
    chk_ready("single_exec", 1'b0, 1'b0);
    check("single_exec_rvalid", {31'b0, resp_valid}, 32'h0);
    check("single_exec_lu_op1", lu_op1, 32'hF0F0_F0F0);
    check("single_exec_lu_opc", {29'b0, lu_operation}, 32'h1);
    req0_valid = 1'b0;
    tick();
    chk_resp("single", 1'b0, 32'hFFFF_FFFF, 1'b0);
    resp_ready = 1'b1;
    tick();
    check("single_idle_rvalid", {31'b0, resp_valid}, 32'h0);
    resp_ready = 1'b0;

    // Contention right after reset: grants alternate 0,1,0,1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_op1 = 32'h1;  req0_op2 = 32'h2;  req0_operation = 3'b001;
    req1_op1 = 32'hFF; req1_op2 = 32'h0F; req1_operation = 3'b010;
    req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_ready("rr_grant", (k % 2) == 0, (k % 2) == 1);
      tick();
      check("rr_exec_rvalid", {31'b0, resp_valid}, 32'h0);
      tick();
      chk_resp("rr", (k % 2) == 1, ((k % 2) == 1) ? 32'h0000_000F : 32'h0000_0003, 1'b0);
      chk_ready("rr_resp", 1'b0, 1'b0);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;

    // Illegal opcode from req1, then held under backpressure for 5 cycles.
    req1_op1 = 32'hFFFF_FFFF; req1_op2 = 32'h0000_1234; req1_operation = 3'b111;
    req1_valid = 1'b1;
    #1;
    chk_ready("ill_accept", 1'b0, 1'b1);
    tick();
    tick();
    req0_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk_resp("bp", 1'b1, 32'h0, 1'b1);
      chk_ready("bp", 1'b0, 1'b0);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
    #1;
    chk_resp("bp_release", 1'b1, 32'h0, 1'b1);
    tick();
    resp_ready = 1'b0;
    check("bp_idle_rvalid", {31'b0, resp_valid}, 32'h0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk_ready("bp_idle_grant", 1'b1, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;

    // Reset during EXEC aborts the operation and clears prio.
    req0_op1 = 32'h5; req0_op2 = 32'h6; req0_operation = 3'b001;
    req0_valid = 1'b1;
    #1;
    chk_ready("abort_accept", 1'b1, 1'b0);
    tick();
    req0_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_lu_op1", lu_op1, 32'h0);
    check("abort_lu_op2", lu_op2, 32'h0);
    check("abort_lu_opc", {29'b0, lu_operation}, 32'h0);
    check("abort_rvalid", {31'b0, resp_valid}, 32'h0);
    check("abort_rid", {31'b0, resp_id}, 32'h0);
    check("abort_rres", resp_res, 32'h0);
    check("abort_rerr", {31'b0, resp_err}, 32'h0);
    tick();
    tick();
    check("abort_noresp", {31'b0, resp_valid}, 32'h0);
    req0_op1 = 32'h0; req0_op2 = 32'h0; req0_operation = 3'b011;
    req1_operation = 3'b001;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk_ready("nor_grant", 1'b1, 1'b0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk_resp("nor", 1'b0, 32'hFFFF_FFFF, 1'b0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // AND / NOR / XOR of A5A5_A5A5 and FFFF_0000.
    req0_op1 = 32'hA5A5_A5A5; req0_op2 = 32'hFFFF_0000;
    for (int i = 0; i < 3; i++) begin
      req0_operation = op_tab[i];
      req0_valid = 1'b1;
      #1;
      chk_ready("ops_accept", 1'b1, 1'b0);
      tick();
      req0_valid = 1'b0;
      tick();
      chk_resp("ops", 1'b0, exp_tab[i], 1'b0);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/logical_arbiter.md
LOGICAL_ARBITER -- requirements
Module: logical_arbiter

Interface
REQ-001 Parameters SHALL be: none; the block has a fixed two-requester, 32-bit configuration.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Ports req0_valid / req1_valid  input  1  requester has an operation pending.
REQ-005 Ports req0_ready / req1_ready  output  1  requester's operation accepted this cycle.
REQ-006 Ports req0_op1, req0_op2 / req1_op1, req1_op2  input  32 each  operands.
REQ-007 Ports req0_operation / req1_operation  input  3  opcode: 001 OR, 010 AND, 011 NOR, 100 XOR.
REQ-008 Ports lu_op1, lu_op2  output  32  operands driven to the shared logical unit.
REQ-009 Port lu_operation  output  3  opcode driven to the shared logical unit.
REQ-010 Port lu_res  input  32  combinational result returned by the shared logical unit.
REQ-011 Port resp_valid  output  1  response available.
REQ-012 Port resp_id  output  1  requester that owns the response: 0 or 1.
REQ-013 Port resp_res  output  32  registered result.
REQ-014 Port resp_err  output  1  opcode was illegal.
REQ-015 Port resp_ready  input  1  consumer accepts the response.

Function
REQ-016 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-017 IDLE: if any reqN_valid=1, the block SHALL grant exactly one requester, assert only that reqN_ready combinationally in the same cycle, capture its op1, op2, operation and id into internal registers, and go to EXEC.
REQ-018 reqN_ready SHALL be 0 in every state other than IDLE, and SHALL be 0 in IDLE when reqN_valid=0.
REQ-019 Arbitration SHALL be round-robin through a 1-bit priority register prio:
  - both valid -> grant requester prio;
  - one valid -> grant that requester regardless of prio;
  - after a grant to requester i, prio <= ~i.
REQ-020 lu_op1, lu_op2 and lu_operation SHALL be driven from the capture registers in all states, so they are stable throughout EXEC.
REQ-021 EXEC lasts exactly one cycle; at its end the block SHALL load resp_res <= lu_res, load resp_id <= the captured id, and go to RESP.
REQ-022 If the captured opcode is not in {001,010,011,100}, then at the end of EXEC the block SHALL set resp_err=1 and resp_res=32'h0000_0000; otherwise resp_err=0.
REQ-023 RESP: resp_valid=1, and resp_id, resp_res and resp_err SHALL be held stable until the cycle in which resp_ready=1.
REQ-024 A RESP cycle with resp_ready=1 SHALL return the FSM to IDLE, with resp_valid=0 from the next cycle; no new grant occurs in that cycle.
REQ-025 resp_valid SHALL be 0 in IDLE and EXEC.
REQ-026 Latency: an accept (ready=1) at cycle N SHALL give resp_valid=1 at cycle N+2; minimum issue interval is 3 cycles.
REQ-027 Requester inputs changing while the FSM is in EXEC or RESP SHALL NOT affect the captured operation.
REQ-028 resp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-029 rst=1 at a clock edge SHALL force: state IDLE, prio 0, all capture registers 0 (lu_op1=0, lu_op2=0, lu_operation=000), resp_valid 0, resp_id 0, resp_res 0, resp_err 0.
REQ-030 rst asserted in EXEC or RESP SHALL abort the operation, produce no response, and apply REQ-029 on the next edge.
REQ-031 During the reset cycle, req0_ready and req1_ready SHALL be 0.

Verification
REQ-032 Single request: req0 op1=F0F0_F0F0, op2=0F0F_FFFF, op=001 -> req0_ready=1 at cycle N; resp_valid=1 at N+2 with resp_id=0, resp_res=FFFF_FFFF, resp_err=0.
REQ-033 Contention: both valid continuously after reset, resp_ready=1 -> grant order 0,1,0,1; each response carries the matching resp_id.
REQ-034 Illegal opcode: req1 op=111 with any operands -> resp_err=1, resp_res=0000_0000, resp_id=1.
REQ-035 Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_* stay constant and both reqN_ready stay 0; resp_ready=1 -> IDLE next cycle.
REQ-036 Mid-operation reset: rst=1 during EXEC -> next cycle all outputs at their reset values and no response is produced; a following req0 NOR of 0 and 0 gives resp_res=FFFF_FFFF.
REQ-037 All opcodes: AND, NOR and XOR of A5A5_A5A5 and FFFF_0000 -> A5A5_0000, 0000_5A5A and 5A5A_A5A5 respectively.
